reg_file_sb: RTL and testbench

Parametrised successor to the 8x8 two-read/one-write register file, used by the core's decode/writeback stages. Adds:
- N read ports
- a second write port for load writeback
- optional write-to-read bypass
- optional hardwired-zero register 0
- a per-register busy scoreboard that tracks outstanding loads and flags hazard errors.

---
 rtl/reg_file_sb.sv | 129 ++++++++++++
 tb/tb_reg_file_sb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : Parametrised register file with NUM_RD combinational read
//               ports, an ALU write port and a load-writeback write port,
//               optional write-to-read bypass, optional hardwired-zero
//               register 0 and a per-register busy scoreboard that tracks
//               outstanding loads and raises sticky hazard errors.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               read_addr/read_val   - packed read ports (port i at slice i)
//               read_busy            - busy bit of each read port's register
//               wr_en/write_addr/val - ALU write port
//               ld_wr_en/ld_write_*  - load writeback port, clears busy
//               ld_issue_en/addr     - load issue, sets busy
//               busy_vec             - registered busy bits
//               err                  - sticky errors {wb-not-busy, issue-busy}
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_RD*AW-1:0]    read_addr,
    output logic [NUM_RD*WIDTH-1:0] read_val,
    output logic [NUM_RD-1:0]       read_busy,
    input  logic                    wr_en,
    input  logic [AW-1:0]           write_addr,
    input  logic [WIDTH-1:0]        write_val,
    input  logic                    ld_wr_en,
    input  logic [AW-1:0]           ld_write_addr,
    input  logic [WIDTH-1:0]        ld_write_val,
    input  logic                    ld_issue_en,
    input  logic [AW-1:0]           ld_issue_addr,
    output logic [DEPTH-1:0]        busy_vec,
    output logic [1:0]              err
);

    localparam logic [AW-1:0] c_ZERO_ADDR = '0;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [1:0]       r_err;

    // Qualified enables: with a hardwired-zero register every operation that
    // targets address 0 is dropped before it reaches storage or scoreboard.
    logic w_wr_ok;
    logic w_ld_ok;
    logic w_iss_ok;

    assign w_wr_ok  = wr_en       && !((ZERO_REG != 0) && (write_addr    == c_ZERO_ADDR));
    assign w_ld_ok  = ld_wr_en    && !((ZERO_REG != 0) && (ld_write_addr == c_ZERO_ADDR));
    assign w_iss_ok = ld_issue_en && !((ZERO_REG != 0) && (ld_issue_addr == c_ZERO_ADDR));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
            r_err  <= '0;
        end else begin
            // The ALU write is issued last so it wins a same-address
            // collision: it belongs to the younger instruction.
            if (w_ld_ok) begin
                r_mem[ld_write_addr] <= ld_write_val;
            end
            if (w_wr_ok) begin
                r_mem[write_addr] <= write_val;
            end

            // Issue is ordered after writeback so a same-register
            // issue+writeback leaves the new load outstanding.
            if (w_ld_ok) begin
                r_busy[ld_write_addr] <= 1'b0;
            end
            if (w_iss_ok) begin
                r_busy[ld_issue_addr] <= 1'b1;
            end

            // Hazards are judged against the busy state before this edge.
            if (w_iss_ok && r_busy[ld_issue_addr]) begin
                r_err[0] <= 1'b1;
            end
            if (w_ld_ok && !r_busy[ld_write_addr]) begin
                r_err[1] <= 1'b1;
            end
        end
    end

    assign busy_vec = r_busy;
    assign err      = r_err;

    generate
        for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
            logic [AW-1:0]    w_ra;
            logic [WIDTH-1:0] w_val;

            assign w_ra = read_addr[g*AW +: AW];

            always_comb begin
                w_val = r_mem[w_ra];
                // Forwarding uses the same ALU-over-load priority as storage,
                // and is held off during reset so reads show stored state.
                if ((BYPASS != 0) && !reset) begin
                    if (w_ld_ok && (ld_write_addr == w_ra)) begin
                        w_val = ld_write_val;
                    end
                    if (w_wr_ok && (write_addr == w_ra)) begin
                        w_val = write_val;
                    end
                end
                if ((ZERO_REG != 0) && (w_ra == c_ZERO_ADDR)) begin
                    w_val = '0;
                end
            end

            assign read_val[g*WIDTH +: WIDTH] = w_val;
            assign read_busy[g]               = r_busy[w_ra];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sb
// Description : Self-checking bench for reg_file_sb. Two instances share the
//               stimulus: dut_a (BYPASS=1, ZERO_REG=0) and dut_z (BYPASS=0,
//               ZERO_REG=1). Expected values are queued as stimulus is
//               driven and compared when the outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  read_addr;
    logic        wr_en;
    logic [2:0]  write_addr;
    logic [7:0]  write_val;
    logic        ld_wr_en;
    logic [2:0]  ld_write_addr;
    logic [7:0]  ld_write_val;
    logic        ld_issue_en;
    logic [2:0]  ld_issue_addr;

    logic [15:0] rv_a, rv_z;
    logic [1:0]  rb_a, rb_z;
    logic [7:0]  bv_a, bv_z;
    logic [1:0]  err_a, err_z;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        int          d;
        int          k;
        int          p;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];

    localparam int K_VAL  = 0;
    localparam int K_RB   = 1;
    localparam int K_BV   = 2;
    localparam int K_ERR  = 3;

    reg_file_sb #(.WIDTH(8), .DEPTH(8), .NUM_RD(2), .BYPASS(1), .ZERO_REG(0)) dut_a (
        .clk(clk), .reset(reset), .read_addr(read_addr), .read_val(rv_a),
        .read_busy(rb_a), .wr_en(wr_en), .write_addr(write_addr),
        .write_val(write_val), .ld_wr_en(ld_wr_en), .ld_write_addr(ld_write_addr),
        .ld_write_val(ld_write_val), .ld_issue_en(ld_issue_en),
        .ld_issue_addr(ld_issue_addr), .busy_vec(bv_a), .err(err_a)
    );

    reg_file_sb #(.WIDTH(8), .DEPTH(8), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .read_addr(read_addr), .read_val(rv_z),
        .read_busy(rb_z), .wr_en(wr_en), .write_addr(write_addr),
        .write_val(write_val), .ld_wr_en(ld_wr_en), .ld_write_addr(ld_write_addr),
        .ld_write_val(ld_write_val), .ld_issue_en(ld_issue_en),
        .ld_issue_addr(ld_issue_addr), .busy_vec(bv_z), .err(err_z)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs(int d, int k, int p);
        logic [15:0] rv;
        logic [1:0]  rb;
        logic [7:0]  bv;
        logic [1:0]  er;
        rv = (d != 0) ? rv_z  : rv_a;
        rb = (d != 0) ? rb_z  : rb_a;
        bv = (d != 0) ? bv_z  : bv_a;
        er = (d != 0) ? err_z : err_a;
        case (k)
            K_VAL:   return 32'(rv[p*8 +: 8]);
            K_RB:    return 32'(rb);
            K_BV:    return 32'(bv);
            default: return 32'(er);
        endcase
    endfunction

    task automatic push(input string tag, input int d, input int k, input int p,
                        input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.d   = d;
        x.k   = k;
        x.p   = p;
        x.exp = e;
        sbq.push_back(x);
    endtask

    // Queue one expectation for each instance.
    task automatic push2(input string tag, input int k, input int p,
                         input logic [31:0] ea, input logic [31:0] ez);
        push(tag, 0, k, p, ea);
        push(tag, 1, k, p, ez);
    endtask

    // Sample 2ns after inputs settle (well away from either clock edge).
    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        #2;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            o = obs(e.d, e.k, e.p);
            n_vec++;
            assert (o === e.exp) else begin
                n_err++;
                $error("FAIL %s dut_%s: observed %0h expected %0h",
                       e.tag, (e.d != 0) ? "z" : "a", o, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en       = 1'b0;
        ld_wr_en    = 1'b0;
        ld_issue_en = 1'b0;
    endtask

    task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1);
        read_addr = {a1, a0};
    endtask

    initial begin
        reset = 1'b1;
        idle();
        write_addr = '0; write_val = '0;
        ld_write_addr = '0; ld_write_val = '0; ld_issue_addr = '0;
        set_rd(3'd0, 3'd0);
        tick();
        tick();

        // Reset state, and bypass held off while reset is high.
        wr_en = 1'b1; write_addr = 3'd3; write_val = 8'hA5;
        set_rd(3'd3, 3'd0);
        push2("rst_rv0_nobyp", K_VAL, 0, 32'h00, 32'h00);
        push2("rst_busy",      K_BV,  0, 32'h00, 32'h00);
        push2("rst_err",       K_ERR, 0, 32'h0,  32'h0);
        drain();
        tick();
        idle();
        reset = 1'b0;
        push2("rst_wr_dropped", K_VAL, 0, 32'h00, 32'h00);
        drain();

        // 1: write with same-cycle read, then stored.
        wr_en = 1'b1; write_addr = 3'd3; write_val = 8'hA5;
        push2("t1_bypass", K_VAL, 0, 32'hA5, 32'h00);
        drain();
        tick();
        idle();
        push2("t1_stored", K_VAL, 0, 32'hA5, 32'hA5);
        drain();

        // 2: ALU and load write same busy register.
        ld_issue_en = 1'b1; ld_issue_addr = 3'd5;
        tick();
        idle();
        wr_en = 1'b1; write_addr = 3'd5; write_val = 8'h11;
        ld_wr_en = 1'b1; ld_write_addr = 3'd5; ld_write_val = 8'h22;
        set_rd(3'd5, 3'd0);
        push2("t2_byp_prio", K_VAL, 0, 32'h11, 32'h00);
        drain();
        tick();
        idle();
        push2("t2_reg5", K_VAL, 0, 32'h11, 32'h11);
        push2("t2_busy", K_BV,  0, 32'h00, 32'h00);
        push2("t2_err",  K_ERR, 0, 32'h0,  32'h0);
        drain();

        // 3: issue, observe busy, writeback clears it.
        ld_issue_en = 1'b1; ld_issue_addr = 3'd2;
        tick();
        idle();
        set_rd(3'd5, 3'd2);
        push2("t3_rbusy", K_RB, 0, 32'h2,  32'h2);
        push2("t3_busy",  K_BV, 0, 32'h04, 32'h04);
        drain();
        ld_wr_en = 1'b1; ld_write_addr = 3'd2; ld_write_val = 8'h7E;
        push2("t3_rbusy_nobyp", K_RB, 0, 32'h2, 32'h2);
        drain();
        tick();
        idle();
        push2("t3_busy_clr", K_BV,  0, 32'h00, 32'h00);
        push2("t3_rv1",      K_VAL, 1, 32'h7E, 32'h7E);
        push2("t3_rbusy0",   K_RB,  0, 32'h0,  32'h0);
        push2("t3_err",      K_ERR, 0, 32'h0,  32'h0);
        drain();

        // 4: double issue, writeback to idle register, then reset.
        ld_issue_en = 1'b1; ld_issue_addr = 3'd4;
        tick();
        tick();
        idle();
        push2("t4_err01", K_ERR, 0, 32'h1,  32'h1);
        push2("t4_busy",  K_BV,  0, 32'h10, 32'h10);
        drain();
        ld_wr_en = 1'b1; ld_write_addr = 3'd6; ld_write_val = 8'h3C;
        set_rd(3'd6, 3'd2);
        tick();
        idle();
        push2("t4_err11", K_ERR, 0, 32'h3,  32'h3);
        push2("t4_reg6",  K_VAL, 0, 32'h3C, 32'h3C);
        push2("t4_busy2", K_BV,  0, 32'h10, 32'h10);
        drain();
        reset = 1'b1;
        tick();
        push2("t4_rst_err",  K_ERR, 0, 32'h0,  32'h0);
        push2("t4_rst_busy", K_BV,  0, 32'h00, 32'h00);
        push2("t4_rst_reg6", K_VAL, 0, 32'h00, 32'h00);
        push2("t4_rst_reg2", K_VAL, 1, 32'h00, 32'h00);
        drain();
        reset = 1'b0;

        // 5: address 0 handling (hardwired zero only in dut_z).
        wr_en = 1'b1; write_addr = 3'd0; write_val = 8'hFF;
        ld_issue_en = 1'b1; ld_issue_addr = 3'd0;
        set_rd(3'd0, 3'd1);
        push2("t5_byp0", K_VAL, 0, 32'hFF, 32'h00);
        drain();
        tick();
        idle();
        push2("t5_rv0",  K_VAL, 0, 32'hFF, 32'h00);
        push2("t5_busy", K_BV,  0, 32'h01, 32'h00);
        push2("t5_err",  K_ERR, 0, 32'h0,  32'h0);
        drain();
        ld_issue_en = 1'b1; ld_issue_addr = 3'd0;
        tick();
        idle();
        push2("t5_reissue0", K_ERR, 0, 32'h1, 32'h0);
        drain();
        ld_wr_en = 1'b1; ld_write_addr = 3'd0; ld_write_val = 8'h77;
        tick();
        idle();
        push2("t5_wb0_rv",   K_VAL, 0, 32'h77, 32'h00);
        push2("t5_wb0_busy", K_BV,  0, 32'h00, 32'h00);
        push2("t5_wb0_err",  K_ERR, 0, 32'h1,  32'h0);
        drain();
        ld_issue_en = 1'b1; ld_issue_addr = 3'd1;
        ld_wr_en = 1'b1; ld_write_addr = 3'd1; ld_write_val = 8'h99;
        tick();
        idle();
        push2("t5_iss_wb_busy", K_BV,  0, 32'h02, 32'h02);
        push2("t5_iss_wb_err",  K_ERR, 0, 32'h3,  32'h2);
        push2("t5_iss_wb_rv1",  K_VAL, 1, 32'h99, 32'h99);
        push2("t5_iss_wb_rb",   K_RB,  0, 32'h2,  32'h2);
        drain();

        // 6: reset overrides same-cycle write and issue.
        reset = 1'b1;
        wr_en = 1'b1; write_addr = 3'd7; write_val = 8'h55;
        ld_issue_en = 1'b1; ld_issue_addr = 3'd7;
        set_rd(3'd7, 3'd1);
        tick();
        idle();
        reset = 1'b0;
        push2("t6_reg7", K_VAL, 0, 32'h00, 32'h00);
        push2("t6_busy", K_BV,  0, 32'h00, 32'h00);
        push2("t6_err",  K_ERR, 0, 32'h0,  32'h0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
